// File: rtl/spi_reg_ctrl.sv
// Command/transaction controller between an SPI slave byte shifter and an 8-bit register file.
// Decodes {rw, addr} command bytes, then runs burst writes or prefetched burst reads.
module spi_reg_ctrl #(
    parameter int          ADDR_W    = 7,
    parameter int          RD_LAT    = 1,
    parameter logic [7:0]  IDLE_BYTE = 8'hA5,
    parameter bit          AUTO_INC  = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cs_active,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_rx_byte,
    output logic [7:0]        o_tx_byte,
    output logic              o_tx_load,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic [7:0]        o_reg_wdata,
    output logic              o_reg_we,
    output logic              o_reg_re,
    input  logic [7:0]        i_reg_rdata,
    output logic              o_busy,
    output logic              o_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR_DATA,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_DATA
    } state_t;

    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    state_t            r_state;
    logic              r_cs_prev;
    logic [2:0]        r_lat_cnt;

    logic              w_byte;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [ADDR_W-1:0] w_addr_next;

    assign w_byte      = i_byte_valid & i_cs_active;
    assign w_addr_inc  = o_reg_addr + 1'b1;
    assign w_addr_next = AUTO_INC ? w_addr_inc : o_reg_addr;
    assign o_busy      = (r_state != S_IDLE);

    // r_cs_prev resets high so a frame already in progress at reset release is ignored
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cs_prev   <= 1'b1;
            r_lat_cnt   <= 3'd0;
            o_tx_byte   <= IDLE_BYTE;
            o_tx_load   <= 1'b0;
            o_reg_addr  <= '0;
            o_reg_wdata <= 8'd0;
            o_reg_we    <= 1'b0;
            o_reg_re    <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            r_cs_prev <= i_cs_active;
            o_tx_load <= 1'b0;
            o_reg_we  <= 1'b0;
            o_reg_re  <= 1'b0;

            // Write address advances after the strobe so reg_we sees the target address
            if (o_reg_we && AUTO_INC) begin
                o_reg_addr <= w_addr_inc;
            end

            if (r_state != S_IDLE && !i_cs_active) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_cs_active && !r_cs_prev) begin
                            r_state   <= S_CMD;
                            o_overrun <= 1'b0;
                            o_tx_byte <= IDLE_BYTE;
                            o_tx_load <= 1'b1;
                        end
                    end
                    S_CMD: begin
                        if (w_byte) begin
                            o_reg_addr <= i_rx_byte[ADDR_W-1:0];
                            if (i_rx_byte[7]) begin
                                r_state  <= S_RD_REQ;
                                o_reg_re <= 1'b1;
                            end else begin
                                r_state <= S_WR_DATA;
                            end
                        end
                    end
                    S_WR_DATA: begin
                        if (w_byte) begin
                            o_reg_wdata <= i_rx_byte;
                            o_reg_we    <= 1'b1;
                            o_tx_byte   <= i_rx_byte;
                            o_tx_load   <= 1'b1;
                        end
                    end
                    S_RD_REQ: begin
                        if (w_byte) begin
                            o_overrun  <= 1'b1;
                            o_reg_addr <= w_addr_next;
                            o_reg_re   <= 1'b1;
                        end else begin
                            r_state   <= S_RD_WAIT;
                            r_lat_cnt <= 3'd0;
                        end
                    end
                    S_RD_WAIT: begin
                        // A byte arriving before data is ready restarts the fetch at the next address
                        if (w_byte) begin
                            o_overrun  <= 1'b1;
                            o_reg_addr <= w_addr_next;
                            o_reg_re   <= 1'b1;
                            r_state    <= S_RD_REQ;
                        end else if (r_lat_cnt == LAT_LAST) begin
                            o_tx_byte <= i_reg_rdata;
                            o_tx_load <= 1'b1;
                            r_state   <= S_RD_DATA;
                        end else begin
                            r_lat_cnt <= r_lat_cnt + 3'd1;
                        end
                    end
                    S_RD_DATA: begin
                        if (w_byte) begin
                            o_reg_addr <= w_addr_next;
                            o_reg_re   <= 1'b1;
                            r_state    <= S_RD_REQ;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: default instance fully checked, plus AUTO_INC=0 and RD_LAT=4 variants.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       bv;
    logic [7:0] rx;

    always #5 clk = ~clk;

    logic [7:0] tx    [3];
    logic       load  [3];
    logic [6:0] addr  [3];
    logic [7:0] wdata [3];
    logic       we    [3];
    logic       re    [3];
    logic [7:0] rdata [3];
    logic       busy  [3];
    logic       ovr   [3];

    spi_reg_ctrl #(.ADDR_W(7), .RD_LAT(1), .IDLE_BYTE(8'hA5), .AUTO_INC(1'b1)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_cs_active(cs), .i_byte_valid(bv), .i_rx_byte(rx),
        .o_tx_byte(tx[0]), .o_tx_load(load[0]), .o_reg_addr(addr[0]), .o_reg_wdata(wdata[0]),
        .o_reg_we(we[0]), .o_reg_re(re[0]), .i_reg_rdata(rdata[0]), .o_busy(busy[0]), .o_overrun(ovr[0])
    );

    spi_reg_ctrl #(.ADDR_W(7), .RD_LAT(1), .IDLE_BYTE(8'hA5), .AUTO_INC(1'b0)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_cs_active(cs), .i_byte_valid(bv), .i_rx_byte(rx),
        .o_tx_byte(tx[1]), .o_tx_load(load[1]), .o_reg_addr(addr[1]), .o_reg_wdata(wdata[1]),
        .o_reg_we(we[1]), .o_reg_re(re[1]), .i_reg_rdata(rdata[1]), .o_busy(busy[1]), .o_overrun(ovr[1])
    );

    spi_reg_ctrl #(.ADDR_W(7), .RD_LAT(4), .IDLE_BYTE(8'hA5), .AUTO_INC(1'b1)) u_dut_c (
        .i_clk(clk), .i_rst(rst), .i_cs_active(cs), .i_byte_valid(bv), .i_rx_byte(rx),
        .o_tx_byte(tx[2]), .o_tx_load(load[2]), .o_reg_addr(addr[2]), .o_reg_wdata(wdata[2]),
        .o_reg_we(we[2]), .o_reg_re(re[2]), .i_reg_rdata(rdata[2]), .o_busy(busy[2]), .o_overrun(ovr[2])
    );

    // Register-file models; read data is garbage except exactly RD_LAT cycles after reg_re
    logic [7:0] mem [3][128];
    logic [7:0] pd  [3][4];
    logic       pv  [3][4];

    function automatic int lat_of(input int i);
        return (i == 2) ? 4 : 1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (we[i]) mem[i][addr[i]] <= wdata[i];
            pd[i][0] <= mem[i][addr[i]];
            pv[i][0] <= re[i];
            for (int j = 1; j < 4; j++) begin
                pd[i][j] <= pd[i][j-1];
                pv[i][j] <= pv[i][j-1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rdata[i] = pv[i][lat_of(i)-1] ? pd[i][lat_of(i)-1] : 8'hEE;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[%0t] FAIL %s: got %0h expected %0h", $time, tag, obs, exp);
        end else begin
            $display("[%0t] pass %s: %0h", $time, tag, obs);
        end
    endtask

    // Scoreboard queues for the default instance, plus a write-address capture for the AUTO_INC=0 one
    logic [7:0]  shadow [128];
    logic [14:0] we_q   [$];
    logic [6:0]  re_q   [$];
    logic [7:0]  tx_q   [$];
    logic [6:0]  b_we_q [$];
    logic [14:0] mon_w;
    logic [6:0]  mon_a;
    logic [7:0]  mon_t;

    always @(negedge clk) begin
        if (!rst) begin
            if (we[0]) begin
                check_eq("we_expected", 32'(we_q.size() != 0), 32'd1);
                check_eq("we_re_excl", 32'(re[0]), 32'd0);
                if (we_q.size() != 0) begin
                    mon_w = we_q.pop_front();
                    check_eq("we_addr_data", {17'd0, addr[0], wdata[0]}, {17'd0, mon_w});
                end
            end
            if (re[0]) begin
                check_eq("re_expected", 32'(re_q.size() != 0), 32'd1);
                if (re_q.size() != 0) begin
                    mon_a = re_q.pop_front();
                    check_eq("re_addr", 32'(addr[0]), 32'(mon_a));
                end
            end
            if (load[0]) begin
                check_eq("tx_load_expected", 32'(tx_q.size() != 0), 32'd1);
                if (tx_q.size() != 0) begin
                    mon_t = tx_q.pop_front();
                    check_eq("tx_byte", 32'(tx[0]), 32'(mon_t));
                end
            end
            if (we[1]) b_we_q.push_back(addr[1]);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start();
        tx_q.push_back(8'hA5);
        cs = 1'b1;
        tick(4);
    endtask

    task automatic frame_end();
        cs = 1'b0;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx = b;
        bv = 1'b1;
        tick(1);
        bv = 1'b0;
        tick(gap);
    endtask

    task automatic wr_frame(input logic [6:0] a, input int n, input logic [23:0] data);
        logic [6:0] p;
        logic [7:0] b;
        p = a;
        frame_start();
        send_byte({1'b0, a}, 16);
        for (int i = 0; i < n; i++) begin
            b = data[23-8*i -: 8];
            we_q.push_back({p, b});
            tx_q.push_back(b);
            shadow[p] = b;
            p = p + 7'd1;
            send_byte(b, 16);
        end
        frame_end();
    endtask

    task automatic rd_frame(input logic [6:0] a, input int n);
        logic [6:0] p;
        p = a;
        frame_start();
        re_q.push_back(p);
        tx_q.push_back(shadow[p]);
        send_byte({1'b1, a}, 16);
        for (int i = 0; i < n; i++) begin
            p = p + 7'd1;
            re_q.push_back(p);
            tx_q.push_back(shadow[p]);
            send_byte(8'h00, 16);
        end
        frame_end();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tx_byte"}, 32'(tx[0]), 32'hA5);
        check_eq({tag, "_strobes"}, {29'd0, load[0], we[0], re[0]}, 32'd0);
        check_eq({tag, "_addr_wdata"}, {17'd0, addr[0], wdata[0]}, 32'd0);
        check_eq({tag, "_busy_ovr"}, {30'd0, busy[0], ovr[0]}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        cs  = 1'b0;
        bv  = 1'b0;
        rx  = 8'h00;
        for (int i = 0; i < 128; i++) shadow[i] = 8'h00;
        tick(3);

        // Reset idle state and frame start
        check_reset_outputs("rst");
        rst = 1'b0;
        tick(2);
        frame_start();
        check_eq("busy_in_frame", 32'(busy[0]), 32'd1);
        frame_end();
        check_eq("busy_after_frame", 32'(busy[0]), 32'd0);

        // Write burst
        wr_frame(7'h05, 3, 24'h112233);

        // Read burst over freshly written registers
        wr_frame(7'h02, 3, 24'hAABBCC);
        rd_frame(7'h02, 3);

        // Address wrap, with the non-incrementing variant capturing its write addresses
        b_we_q.delete();
        wr_frame(7'h7F, 2, 24'h010200);
        check_eq("noinc_we_count", 32'(b_we_q.size()), 32'd2);
        if (b_we_q.size() == 2) begin
            check_eq("noinc_we0_addr", 32'(b_we_q[0]), 32'h7F);
            check_eq("noinc_we1_addr", 32'(b_we_q[1]), 32'h7F);
        end

        // Abort during RD_WAIT: read strobe issued, no load, idle next clock
        frame_start();
        re_q.push_back(7'h03);
        rx = 8'h83;
        bv = 1'b1;
        tick(1);
        bv = 1'b0;
        tick(1);
        cs = 1'b0;
        tick(1);
        check_eq("abort_busy_a", 32'(busy[0]), 32'd0);
        check_eq("abort_busy_c", 32'(busy[2]), 32'd0);
        tick(4);
        wr_frame(7'h20, 1, 24'h5A0000);

        // Overrun on the RD_LAT=4 instance: byte arrives two clocks after reg_re
        frame_start();
        re_q.push_back(7'h04);
        tx_q.push_back(shadow[4]);
        rx = 8'h84;
        bv = 1'b1;
        tick(1);
        bv = 1'b0;
        tick(2);
        re_q.push_back(7'h05);
        tx_q.push_back(shadow[5]);
        rx = 8'h00;
        bv = 1'b1;
        tick(1);
        bv = 1'b0;
        tick(1);
        check_eq("overrun_lat4_set", 32'(ovr[2]), 32'd1);
        check_eq("overrun_lat1_clear", 32'(ovr[0]), 32'd0);
        tick(16);
        frame_end();
        check_eq("overrun_sticky", 32'(ovr[2]), 32'd1);
        frame_start();
        check_eq("overrun_cleared", 32'(ovr[2]), 32'd0);
        frame_end();

        // Reset in the middle of a write burst
        frame_start();
        send_byte(8'h10, 16);
        rx = 8'h77;
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        bv = 1'b1;
        tick(1);
        bv = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
        send_byte(8'h78, 16);
        check_eq("ignored_frame_busy", 32'(busy[0]), 32'd0);
        frame_end();
        wr_frame(7'h30, 2, 24'hC3D400);

        tick(20);
        check_eq("we_q_left", 32'(we_q.size()), 32'd0);
        check_eq("re_q_left", 32'(re_q.size()), 32'd0);
        check_eq("tx_q_left", 32'(tx_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
